// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a write buffer in front of the FSM.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_full,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_ovf,
  output logic        TX
);

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  // holding register only: one entry whatever FIFO_DEPTH says
  localparam int DEPTH = 1 + 0 * FIFO_DEPTH;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [OW-1:0] occ_q, occ_d;

  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_ok;
  logic          bit_end;
  logic [15:0]   div_eff;
  logic [7:0]    head;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OW'(DEPTH));
  assign head    = mem_q[rp_q];
  assign bit_end = (cnt_q == div_q - 16'd1);
  assign div_eff = (baud_div < 16'd2) ? 16'd2 : baud_div;
  // a full buffer still takes a write in the cycle the FSM pops
  assign wr_ok   = tx_wr & ~rst & (~full | pop);

  assign tx_full = full;
  // done_q covers the final stop cycle, which the line shows one cycle late
  assign tx_busy = (state_q != IDLE) | ~empty | done_q;
  assign tx_done = done_q;
  assign tx_ovf  = ovf_q;
  assign TX      = tx_q;

  // buffer storage, no reset needed on data
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wp_q] <= tx_data;
    end
  end

  // buffer pointers, occupancy and sticky overflow
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    occ_d = occ_q;
    ovf_d = ovf_q | (tx_wr & full & ~pop);
    if (wr_ok) begin
      wp_d = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + AW'(1);
    end
    unique case ({wr_ok, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and bit/baud counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    div_d   = div_q;
    byte_d  = byte_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          state_d = START;
          div_d   = div_eff;
          byte_d  = head;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            state_d = START;
            div_d   = div_eff;
            byte_d  = head;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: line level, end-of-stop pulse, buffer pop
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop = ~empty;
      end
      START: begin
        tx_d = 1'b0;
      end
      DATA: begin
        tx_d = byte_q[bit_q];
      end
      STOP: begin
        done_d = bit_end;
        pop    = bit_end & ~empty;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // datapath registers; line and done are registered so they stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      tx_q   <= tx_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed vectors and corner sequences for uart_tx.
// Works with or without UART_TX_FIFO_EN defined.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_ovf;
  logic        TX;

  int vecs = 0;
  int miss = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    int          bl;
  } vec_t;

  vec_t vt [5];

  uart_tx #(.FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_ovf   (tx_ovf),
    .TX       (TX)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // check {TX,tx_done,tx_busy} over one frame from frame cycle i0
  task automatic frame(input logic [7:0] d, input int bl, input int i0,
                       input string nm);
    int bad_i;
    logic [2:0] got;
    logic [2:0] want;
    bad_i = -1;
    got = '0;
    want = '0;
    for (int i = i0; i < 10 * bl; i++) begin
      int k;
      logic et;
      logic [2:0] w;
      @(negedge clk);
      k = i / bl;
      et = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      w = {et, (i == 10 * bl - 1), 1'b1};
      if (bad_i < 0 && {TX, tx_done, tx_busy} !== w) begin
        bad_i = i;
        got = {TX, tx_done, tx_busy};
        want = w;
      end
    end
    vecs++;
    if (bad_i >= 0) begin
      miss++;
      $display("FAIL %s: cycle %0d TX/done/busy got %b expected %b",
               nm, bad_i, got, want);
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    chk(nm, {TX, tx_done, tx_busy}, 32'b100);
  endtask

  // single write into an idle block, then the whole frame
  task automatic send(input logic [7:0] d, input logic [15:0] div,
                      input int bl, input string nm);
    baud_div = div;
    @(negedge clk);
    tx_data = d;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    @(negedge clk);
    chk({nm, " pre-start"}, {TX, tx_busy}, 32'b11);
    baud_div = div + 16'd5;
    frame(d, bl, 0, nm);
    idle_check({nm, " idle after"});
  endtask

  // line-side receiver for baud 233, sampling mid-bit
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = '0;
    for (int n = 0; n < 6000 && TX !== 1'b0; n++) @(negedge clk);
    if (TX !== 1'b0) return;
    repeat (116) @(negedge clk);
    if (TX !== 1'b0) return;
    for (int j = 0; j < 8; j++) begin
      repeat (233) @(negedge clk);
      b[j] = TX;
    end
    repeat (233) @(negedge clk);
    ok = (TX === 1'b1);
  endtask

  initial begin
    logic [7:0] r0, r1;
    bit ok0, ok1;
    int d0;
    int bad;
    logic exp_full;

    vt[0] = '{16'd233, 8'h55, 233};
    vt[1] = '{16'd1,   8'hFF, 2};
    vt[2] = '{16'd0,   8'h00, 2};
    vt[3] = '{16'd2,   8'hA5, 2};
    vt[4] = '{16'd7,   8'h3C, 7};

    rst = 1'b1;
    tx_wr = 1'b0;
    tx_data = 8'h00;
    baud_div = 16'd233;
    repeat (3) @(negedge clk);
    chk("reset TX", TX, 1);
    chk("reset flags", {tx_done, tx_ovf, tx_full, tx_busy}, 0);
    rst = 1'b0;
    idle_check("idle after reset");

    for (int v = 0; v < 5; v++) begin
      send(vt[v].data, vt[v].div, vt[v].bl, $sformatf("vec%0d", v));
    end

    // back-to-back frames, no idle gap
    baud_div = 16'd233;
    @(negedge clk);
    tx_data = 8'h55;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_data = 8'hAA;
    @(negedge clk);
    tx_wr = 1'b0;
`ifdef UART_TX_FIFO_EN
    exp_full = 1'b0;
`else
    exp_full = 1'b1;
`endif
    chk("b2b pre-start", {TX, tx_full}, {31'd0, 1'b1, exp_full});
    d0 = done_cnt;
    frame(8'h55, 233, 0, "b2b first");
    frame(8'hAA, 233, 0, "b2b second");
    idle_check("b2b idle");
    chk("b2b done count", done_cnt - d0, 2);

`ifdef UART_TX_FIFO_EN
    // ten writes into an eight-deep buffer
    baud_div = 16'd233;
    @(negedge clk);
    tx_data = 8'h00;
    tx_wr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("fifo full after write %0d", k), tx_full, (k >= 9));
      if (k < 10) tx_data = 8'(k);
      else tx_wr = 1'b0;
    end
    chk("fifo ovf", tx_ovf, 1);
    frame(8'h00, 233, 8, "fifo byte0");
    for (int k = 1; k <= 8; k++) begin
      frame(8'(k), 233, 0, $sformatf("fifo byte%0d", k));
    end
    idle_check("fifo idle");
    chk("fifo ovf sticky", tx_ovf, 1);
`else
    // holding register: third write in a row is dropped
    baud_div = 16'd4;
    @(negedge clk);
    tx_data = 8'hA1;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_data = 8'hB2;
    @(negedge clk);
    tx_data = 8'hC3;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("ovf set", {TX, tx_full, tx_ovf}, 32'b011);
    frame(8'hA1, 4, 1, "ovf byte A1");
    frame(8'hB2, 4, 0, "ovf byte B2");
    idle_check("ovf idle");
    chk("ovf sticky", tx_ovf, 1);
`endif

    // reset during DATA bit 3 of 0xA5, with a write on the reset cycle
    baud_div = 16'd5;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    @(negedge clk);
    repeat (22) @(negedge clk);
    chk("mid-frame line", TX, 0);
    d0 = done_cnt;
    rst = 1'b1;
    tx_wr = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    chk("abort TX", TX, 1);
    chk("abort flags", {tx_busy, tx_ovf, tx_full, tx_done}, 0);
    rst = 1'b0;
    tx_wr = 1'b0;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("quiet after abort", bad, 0);
    chk("no done after abort", done_cnt - d0, 0);
    send(8'h3C, 16'd5, 5, "after abort");

    // loopback into a line receiver
    d0 = done_cnt;
    fork
      begin
        baud_div = 16'd233;
        @(negedge clk);
        tx_data = 8'h55;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        @(negedge clk);
        tx_wr = 1'b0;
      end
      begin
        rx_byte(r0, ok0);
        rx_byte(r1, ok1);
      end
    join
    chk("loop rx0", {ok0, r0}, {1'b1, 8'h55});
    chk("loop rx1", {ok1, r1}, {1'b1, 8'hAA});
    repeat (200) @(negedge clk);
    chk("loop done count", done_cnt - d0, 2);
    chk("loop idle", {TX, tx_busy}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
